phoenix_switch_control: RTL and testbench
=========================================

// Module: phoenix_switch_control
// PURPOSE
// Central routing/arbitration stage of the Phoenix router, directly downstream of the five
// per-port input buffers. Collects buffer routing requests (h), arbitrates round-robin,
// computes the XY-routed output port from each header flit and acknowledges the winner
// (ack_h). Holds the crossbar connection until that buffer's sender drops, then frees it.
// Port index: EAST=0, WEST=1, NORTH=2, SOUTH=3, LOCAL=4. Flit width is the global `TAM_FLIT (8).
// PARAMETERS
// ADDRESS  8'h11  router address; [`TAM_FLIT-1:`TAM_FLIT/2]=X, [`TAM_FLIT/2-1:0]=Y
// NPORT    5      number of ports (fixed; other values unsupported)
// PORTS
// clock    in   1               single clock; all logic on posedge
// reset    in   1               synchronous, active-high
// h        in   NPORT           routing request per input buffer
// data     in   NPORT*`TAM_FLIT buffer head flits; slice i = data[i*`TAM_FLIT +: `TAM_FLIT]
// sender   in   NPORT           input buffer i is forwarding a packet
// ack_h    out  NPORT           one-cycle routing grant to input i
// free     out  NPORT           output port j is unallocated
// mux_in   out  NPORT*3         per output j: input index driving it; 3'd7 = none
// mux_out  out  NPORT*3         per input i: output index it drives; 3'd7 = none
// BEHAVIOUR
// - Reset: ack_h=0, free=5'b11111, all mux_in/mux_out=3'd7, prio=4, sender_q=0, state=S_IDLE.
// - All outputs registered. FSM, one state per cycle:
//   S_IDLE : if |h -> S_ARB, else stay.
//   S_ARB  : sel <= first i with h[i]=1, searching (prio+1)..(prio+5) mod 5 -> S_ROUTE.
//            If h has dropped to 0 -> S_IDLE.
//   S_ROUTE: dest <= XY(data slice sel) -> S_CHECK.
//   S_CHECK: if free[dest]: free[dest]<=0, mux_in[dest]<=sel, mux_out[sel]<=dest -> S_ACK;
//            else prio<=sel, no ack -> S_IDLE (requester keeps h high and retries later).
//   S_ACK  : ack_h[sel]=1 for exactly this cycle, prio<=sel -> S_IDLE.
// - Latency: h sampled in S_IDLE at cycle N -> ack_h high in cycle N+4 when output free.
// - XY rule (tx,ty from header; lx,ly from ADDRESS; unsigned compare):
//   tx>lx EAST; tx<lx WEST; else ty>ly NORTH; ty<ly SOUTH; else LOCAL.
// - Release: sender_q<=sender each cycle. Falling edge on input i with mux_out[i]!=7:
//   next cycle free[mux_out[i]]=1, mux_in[mux_out[i]]=7, mux_out[i]=7. Any subset of
//   inputs may release in the same cycle; all are applied.
// - Simultaneous release and S_CHECK: S_CHECK uses the registered free (pre-release);
//   release of output j in same cycle as check for j -> check fails, retry.
//   Release and grant of different outputs in same cycle -> both applied.
// - At most one ack_h bit high at any time; ack_h never asserted for an input with h=0
//   at the S_ARB sample.
// - Falling sender with mux_out[i]=7 (no connection) is ignored.
// - Reset mid-operation (any state) restores full reset state next cycle; a pending ack
//   is dropped.
// TESTING
// 1 Reset held 2 cycles -> free=5'b11111, ack_h=0, mux_in/mux_out all 3'd7.
// 2 ADDRESS=8'h11, h[4]=1, data[4]=8'h21 at N -> ack_h=5'b10000 at N+4 only,
//   mux_out[4]=0, mux_in[0]=4, free=5'b11110.
// 3 Headers 8'h01/8'h12/8'h10 from input 0 (successive packets, sender released between)
//   -> dest WEST(1)/NORTH(2)/SOUTH(3).
// 4 h[0],h[1] both header 8'h11 -> input 0 acked; input 1 retries, no ack while
//   sender[0]=1; sender[0] falls at M -> free[4]=1 at M+1, ack_h[1] follows.
// 5 All five h high, distinct destinations -> acks in order 0,1,2,3,4, one per 5 cycles.
// 6 reset pulsed while state=S_CHECK with free dest -> no ack_h, free=5'b11111 after.

Source files
------------

// File: rtl/phoenix_switch_control.sv
// Phoenix router switch control: collects routing requests from the five
// input buffers, arbitrates them round-robin, computes the XY output port
// from the winner's header flit, and holds the crossbar connection until the
// winning buffer stops sending.
// Port index: EAST=0, WEST=1, NORTH=2, SOUTH=3, LOCAL=4.

`ifndef TAM_FLIT
`define TAM_FLIT 8
`endif

module phoenix_switch_control #(
    parameter logic [`TAM_FLIT-1:0] ADDRESS = 8'h11,
    parameter int                   NPORT   = 5
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic [NPORT-1:0]           h,
    input  logic [NPORT*`TAM_FLIT-1:0] data,
    input  logic [NPORT-1:0]           sender,
    output logic [NPORT-1:0]           ack_h,
    output logic [NPORT-1:0]           free,
    output logic [NPORT*3-1:0]         mux_in,
    output logic [NPORT*3-1:0]         mux_out
);

    localparam int HALF = `TAM_FLIT / 2;

    // Port codes; NONE marks an unconnected crossbar path.
    localparam logic [2:0] P_EAST  = 3'd0;
    localparam logic [2:0] P_WEST  = 3'd1;
    localparam logic [2:0] P_NORTH = 3'd2;
    localparam logic [2:0] P_SOUTH = 3'd3;
    localparam logic [2:0] P_LOCAL = 3'd4;
    localparam logic [2:0] NONE    = 3'd7;

    // This router's own coordinates.
    localparam logic [HALF-1:0] LX = ADDRESS[`TAM_FLIT-1:HALF];
    localparam logic [HALF-1:0] LY = ADDRESS[HALF-1:0];

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARB,
        S_ROUTE,
        S_CHECK,
        S_ACK
    } state_t;

    state_t state;
    state_t state_next;

    logic [2:0]          sel;          // input being served
    logic [2:0]          dest;         // output requested by sel
    logic [2:0]          prio;         // last input served; search starts after it
    logic [NPORT-1:0]    sender_q;     // sender delayed one cycle, for edge detect
    logic [NPORT-1:0]    falls;        // sender falling edges this cycle

    logic [2:0]          mux_in_r  [NPORT];
    logic [2:0]          mux_out_r [NPORT];
    logic [`TAM_FLIT-1:0] flit     [NPORT];

    logic                arb_hit;
    logic [2:0]          arb_sel;
    logic [3:0]          cand;

    logic [`TAM_FLIT-1:0] head;
    logic [HALF-1:0]     tx;
    logic [HALF-1:0]     ty;
    logic [2:0]          route_dest;

    logic                grant;

    // Split the packed head-flit bus into one flit per input.
    always_comb begin
        for (int i = 0; i < NPORT; i++) begin
            flit[i] = data[i*`TAM_FLIT +: `TAM_FLIT];
        end
    end

    // Round-robin search: first requester after prio, wrapping once around.
    always_comb begin
        // NOTE: every variable written here gets a default first, so no path
        // leaves it unassigned and no latch is inferred.
        arb_hit = 1'b0;
        arb_sel = prio;
        cand    = '0;
        for (int k = 1; k <= NPORT; k++) begin
            cand = {1'b0, prio} + 4'(k);
            if (cand >= 4'(NPORT)) begin
                cand = cand - 4'(NPORT);
            end
            if (!arb_hit && h[cand[2:0]]) begin
                arb_hit = 1'b1;
                arb_sel = cand[2:0];
            end
        end
    end

    // XY routing of the selected input's header: resolve X first, then Y.
    always_comb begin
        head = flit[sel];
        tx   = head[`TAM_FLIT-1:HALF];
        ty   = head[HALF-1:0];
        if (tx > LX) begin
            route_dest = P_EAST;
        end else if (tx < LX) begin
            route_dest = P_WEST;
        end else if (ty > LY) begin
            route_dest = P_NORTH;
        end else if (ty < LY) begin
            route_dest = P_SOUTH;
        end else begin
            route_dest = P_LOCAL;
        end
    end

    // A check succeeds only against the registered free map, so an output
    // released in this same cycle is not yet seen as available.
    assign grant = (state == S_CHECK) && free[dest];

    // Connections are torn down only for inputs that actually hold one.
    assign falls = sender_q & ~sender;

    // State register.
    always_ff @(posedge clock) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of block ordering.
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: one FSM step per cycle.
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:  if (|h) state_next = S_ARB;
            S_ARB:   state_next = arb_hit ? S_ROUTE : S_IDLE;
            S_ROUTE: state_next = S_CHECK;
            S_CHECK: state_next = grant ? S_ACK : S_IDLE;
            S_ACK:   state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // Capture winner, its destination, and the round-robin pointer.
    always_ff @(posedge clock) begin
        if (reset) begin
            sel  <= 3'd0;
            dest <= 3'd0;
            prio <= P_LOCAL;
        end else begin
            case (state)
                S_ARB:   if (arb_hit) sel <= arb_sel;
                S_ROUTE: dest <= route_dest;
                S_CHECK: if (!grant) prio <= sel;
                S_ACK:   prio <= sel;
                default: ;
            endcase
        end
    end

    // One-cycle acknowledge, visible during S_ACK.
    always_ff @(posedge clock) begin
        if (reset) begin
            ack_h <= '0;
        end else if (grant) begin
            ack_h <= {{(NPORT-1){1'b0}}, 1'b1} << sel;
        end else begin
            ack_h <= '0;
        end
    end

    // Sender history for falling-edge detection.
    always_ff @(posedge clock) begin
        if (reset) begin
            sender_q <= '0;
        end else begin
            sender_q <= sender;
        end
    end

    // Crossbar allocation: apply every release, then any new grant.
    always_ff @(posedge clock) begin
        if (reset) begin
            // NOTE: the connection tables are small register arrays that drive
            // outputs directly, so they are reset like any other state.
            free <= '1;
            for (int i = 0; i < NPORT; i++) begin
                mux_in_r[i]  <= NONE;
                mux_out_r[i] <= NONE;
            end
        end else begin
            for (int i = 0; i < NPORT; i++) begin
                if (falls[i] && (mux_out_r[i] != NONE)) begin
                    free[mux_out_r[i]]     <= 1'b1;
                    mux_in_r[mux_out_r[i]] <= NONE;
                    mux_out_r[i]           <= NONE;
                end
            end
            // A granted output was free, so no release above can target it.
            if (grant) begin
                free[dest]     <= 1'b0;
                mux_in_r[dest] <= sel;
                mux_out_r[sel] <= dest;
            end
        end
    end

    // Pack the connection tables onto the output buses.
    always_comb begin
        for (int i = 0; i < NPORT; i++) begin
            mux_in[i*3 +: 3]  = mux_in_r[i];
            mux_out[i*3 +: 3] = mux_out_r[i];
        end
    end

endmodule

// File: tb/tb_phoenix_switch_control.sv
// Self-checking bench for phoenix_switch_control: directed scenarios plus
// randomized request rounds, scored against a transaction-level model.
module tb_phoenix_switch_control;

    localparam int NP = 5;
    localparam int FW = 8;

    logic            clock = 1'b0;
    logic            reset = 1'b1;
    logic [NP-1:0]   h;
    logic [NP*FW-1:0] data = '0;
    logic [NP-1:0]   sender;
    logic [NP-1:0]   ack_h;
    logic [NP-1:0]   free;
    logic [NP*3-1:0] mux_in;
    logic [NP*3-1:0] mux_out;

    // Buffer-side model: a buffer requests while h_req is set and it has not
    // been acknowledged; once acknowledged it sends while tx_on allows.
    logic [NP-1:0]   h_req = '0;
    logic [NP-1:0]   tx_on = '1;
    logic [NP-1:0]   acked = '0;

    assign h      = h_req & ~acked;
    assign sender = acked & tx_on;

    phoenix_switch_control #(
        .ADDRESS (8'h11),
        .NPORT   (5)
    ) dut (
        .clock   (clock),
        .reset   (reset),
        .h       (h),
        .data    (data),
        .sender  (sender),
        .ack_h   (ack_h),
        .free    (free),
        .mux_in  (mux_in),
        .mux_out (mux_out)
    );

    always #5 clock = ~clock;

    typedef struct {
        int in_port;
        int out_port;
    } grant_t;

    grant_t exp_q[$];
    int     ack_cycle[$];
    int     errors = 0;
    int     checks = 0;
    int     cyc    = 0;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    // Monitor: every acknowledge is scored against the next expected grant.
    always @(negedge clock) begin
        grant_t g;
        if ((|ack_h) === 1'b1) begin
            ack_cycle.push_back(cyc);
            if (exp_q.size() == 0) begin
                check("unexpected_ack", 32'(ack_h), 32'd0);
            end else begin
                g = exp_q.pop_front();
                check("ack_h", 32'(ack_h), 32'(1 << g.in_port));
                check("mux_out_conn", 32'(mux_out[g.in_port*3 +: 3]), 32'(g.out_port));
                check("mux_in_conn", 32'(mux_in[g.out_port*3 +: 3]), 32'(g.in_port));
                check("free_taken", 32'(free[g.out_port]), 32'd0);
            end
        end
        acked <= (acked & h_req) | ((|ack_h) === 1'b1 ? ack_h : '0);
    end

    // Reference routing: X first, then Y, against router address (1,1).
    function automatic int xy_dest(input logic [7:0] hdr);
        int tx;
        int ty;
        tx = int'(hdr[7:4]);
        ty = int'(hdr[3:0]);
        if (tx > 1) return 0;
        if (tx < 1) return 1;
        if (ty > 1) return 2;
        if (ty < 1) return 3;
        return 4;
    endfunction

    task automatic tick(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic set_flit(input int p, input logic [7:0] v);
        data[p*FW +: FW] = v;
    endtask

    task automatic drain(input int budget);
        int t;
        t = 0;
        while (exp_q.size() != 0 && t < budget) begin
            tick(1);
            t++;
        end
        check("drain_pending", 32'(exp_q.size()), 32'd0);
        exp_q.delete();
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_free"}, 32'(free), 32'h1f);
        check({tag, "_mux"}, 32'({mux_in, mux_out}), 32'h3fff_ffff);
        check({tag, "_ack"}, 32'(ack_h), 32'd0);
    endtask

    // Release all senders, verify the crossbar is empty, then retire requests.
    task automatic end_round(input string tag);
        tx_on = '0;
        tick(2);
        check_idle(tag);
        h_req = '0;
        tick(2);
        tx_on = '1;
        tick(1);
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        tick(1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] hdr;
        logic [4:0] req;
        logic [4:0] blk;
        int         dst [NP];
        bit         taken [NP];
        int         model_prio;
        int         last;
        int         p;
        int         base;
        logic [7:0] hdrs3 [3];
        int         dsts3 [3];
        logic [7:0] hdrs5 [5];

        // Reset held two cycles.
        reset = 1'b1;
        tick(2);
        check_idle("reset");
        reset = 1'b0;
        tick(1);

        // Single LOCAL-buffer request heading east: ack exactly 4 cycles later.
        exp_q.push_back('{4, 0});
        set_flit(4, 8'h21);
        h_req[4] = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            tick(1);
            check("ack_early", 32'(ack_h), 32'd0);
        end
        tick(1);
        check("ack_latency", 32'(ack_h), 32'h10);
        check("free_after_grant", 32'(free), 32'h1e);
        tick(1);
        check("ack_one_cycle", 32'(ack_h), 32'd0);
        end_round("t2");

        // Successive packets from input 0 routed WEST, NORTH, SOUTH.
        hdrs3[0] = 8'h01; dsts3[0] = 1;
        hdrs3[1] = 8'h12; dsts3[1] = 2;
        hdrs3[2] = 8'h10; dsts3[2] = 3;
        for (int k = 0; k < 3; k++) begin
            exp_q.push_back('{0, dsts3[k]});
            set_flit(0, hdrs3[k]);
            h_req[0] = 1'b1;
            drain(40);
            tick(1);
            end_round("t3");
        end

        // Contention for LOCAL: input 0 wins, input 1 waits for the release.
        pulse_reset();
        set_flit(0, 8'h11);
        set_flit(1, 8'h11);
        exp_q.push_back('{0, 4});
        h_req = 5'b00011;
        drain(40);
        tick(20);
        check("blocked_free4", 32'(free[4]), 32'd0);
        exp_q.push_back('{1, 4});
        tx_on[0] = 1'b0;
        tick(1);
        check("release_free4", 32'(free[4]), 32'd1);
        check("release_mux_out0", 32'(mux_out[2:0]), 32'd7);
        drain(40);
        tick(1);
        end_round("t4");

        // Reset while the FSM is checking a free destination: no ack.
        tick(4);
        set_flit(3, 8'h10);
        h_req[3] = 1'b1;
        tick(3);
        reset = 1'b1;
        h_req = '0;
        tick(1);
        reset = 1'b0;
        check_idle("t6_reset");
        tick(8);
        check("t6_no_ack", 32'(ack_h), 32'd0);

        // All five request distinct outputs: served 0..4, one every 5 cycles.
        hdrs5[0] = 8'h21; hdrs5[1] = 8'h01; hdrs5[2] = 8'h12;
        hdrs5[3] = 8'h10; hdrs5[4] = 8'h11;
        for (int i = 0; i < NP; i++) begin
            set_flit(i, hdrs5[i]);
            exp_q.push_back('{i, i});
        end
        base = ack_cycle.size();
        h_req = '1;
        drain(100);
        check("t5_ack_count", 32'(ack_cycle.size() - base), 32'd5);
        for (int k = base + 1; k < ack_cycle.size(); k++) begin
            check("t5_spacing", 32'(ack_cycle[k] - ack_cycle[k-1]), 32'd5);
        end
        tick(1);
        end_round("t5");

        // Randomized rounds: the model serves requesters in circular order
        // after the last served input, granting the first claimant of each
        // output; later claimants stay blocked while nothing is released.
        model_prio = 4;
        for (int r = 0; r < 24; r++) begin
            req = 5'($urandom_range(1, 31));
            blk = '0;
            last = model_prio;
            for (int i = 0; i < NP; i++) begin
                hdr[7:4] = 4'($urandom_range(0, 2));
                hdr[3:0] = 4'($urandom_range(0, 2));
                set_flit(i, hdr);
                dst[i]   = xy_dest(hdr);
                taken[i] = 1'b0;
            end
            for (int k = 1; k <= NP; k++) begin
                p = (model_prio + k) % NP;
                if (req[p]) begin
                    if (!taken[dst[p]]) begin
                        taken[dst[p]] = 1'b1;
                        exp_q.push_back('{p, dst[p]});
                        last = p;
                    end else begin
                        blk[p] = 1'b1;
                    end
                end
            end
            h_req = req;
            drain(200);
            tick(15);
            if (blk != '0) begin
                h_req = h_req & ~blk;
                tick(8);
            end
            end_round("rnd");
            if (blk != '0) begin
                pulse_reset();
                model_prio = 4;
            end else begin
                model_prio = last;
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
